// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data memory bank.
// Access sizes, sweep states and the response pipeline stage bundle.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_RSVD
  } mem_size_t;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        fault;
  } rsp_stage_t;

  localparam int MAX_READ_LATENCY = 4;

  function automatic int clamp_lat(input int lat);
    if (lat < 1)
      return 1;
    if (lat > MAX_READ_LATENCY)
      return MAX_READ_LATENCY;
    return lat;
  endfunction

endpackage

// File: rtl/data_mem_bank_if.sv
// Request/response bundle between the MEM stage and the data bank.
// The bank is the slave; the pipeline (or a bench) is the master.
interface data_mem_bank_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_fault
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_fault
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word loads and stores.
// Purely combinational; range checks live in the bank.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic        zext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wshift,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [31:0] bsh;
  logic [31:0] hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = raw >> {lane, 3'b000};
  assign hsh = raw >> {lane[1], 4'b0000};
  assign b   = bsh[7:0];
  assign h   = hsh[15:0];

  always_comb begin
    be       = 4'h0;
    wshift   = 32'h0;
    ldata    = 32'h0;
    misalign = 1'b0;
    unique case (1'b1)
      (size == MEM_B): begin
        be     = 4'b0001 << lane;
        wshift = {4{wdata[7:0]}};
        ldata  = zext ? {24'h0, b}
                      : {{24{b[7]}}, b};
      end
      (size == MEM_H): begin
        misalign = lane[0];
        be       = 4'b0011 << lane;
        wshift   = {2{wdata[15:0]}};
        ldata    = zext ? {16'h0, h}
                        : {{16{h[15]}}, h};
      end
      (size == MEM_W): begin
        misalign = (lane != 2'b00);
        be       = 4'hF;
        wshift   = wdata;
        ldata    = raw;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// MEM-stage data memory: sub-word access, fault detection,
// post-reset clear sweep and a fixed-latency response pipeline.
module data_mem_bank
  import mem_pkg::*;
#(
  parameter int          NUM_WORDS    = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic clk,
  input  logic n_rst,
  data_mem_bank_if.slave bus
);

  localparam int AW  = $clog2(NUM_WORDS);
  localparam int LAT = clamp_lat(READ_LATENCY);

  state_t         state;
  logic [AW-1:0]  cnt;
  logic           ready;

  logic [31:0]    mem [NUM_WORDS];

  logic [31:0]    off;
  logic [29:0]    idx;
  logic [1:0]     lane;
  logic [AW-1:0]  widx;
  logic           range_bad;
  logic           misalign;
  logic           fault;
  logic           accept;
  logic           store;
  logic [3:0]     be;
  logic [31:0]    wshift;
  logic [31:0]    ldata;
  logic [31:0]    raw;

  rsp_stage_t     nxt;
  rsp_stage_t     pipe [LAT];

  // Underflow below BASE_ADDR wraps to a huge index and faults.
  assign off       = bus.req_addr - BASE_ADDR;
  assign idx       = off[31:2];
  assign lane      = off[1:0];
  assign widx      = idx[AW-1:0];
  assign range_bad = (idx >= 30'(NUM_WORDS));
  assign raw       = mem[widx];

  mem_lane_align u_align (
    .size     (mem_size_t'(bus.req_size)),
    .zext     (bus.req_unsigned),
    .lane     (lane),
    .wdata    (bus.req_wdata),
    .raw      (raw),
    .be       (be),
    .wshift   (wshift),
    .ldata    (ldata),
    .misalign (misalign)
  );

  assign fault  = range_bad | misalign;
  assign accept = bus.req_valid & ready;
  assign store  = accept & bus.req_write & ~fault;

  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NUM_WORDS - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Contents are cleared by the sweep, never by the reset itself.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[widx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  always_comb begin
    nxt       = '0;
    nxt.valid = accept;
    nxt.fault = accept & fault;
    if (accept && !bus.req_write && !fault)
      nxt.rdata = ldata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= nxt;
      for (int i = 1; i < LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign bus.rsp_valid = pipe[LAT-1].valid;
  assign bus.rsp_rdata = pipe[LAT-1].rdata;
  assign bus.rsp_fault = pipe[LAT-1].fault;

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed plus randomized bench for data_mem_bank against a
// byte-addressed reference memory and a timed response queue.
module tb_data_mem_bank;

  localparam int NW   = 16;
  localparam int LAT  = 2;
  localparam int NB   = NW * 4;
  localparam logic [31:0] BASE = 32'h0;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        flt;
    string       tag;
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  logic [7:0] ref_mem [NB];
  exp_t       expq [$];

  data_mem_bank_if bus ();

  data_mem_bank #(
    .NUM_WORDS    (NW),
    .READ_LATENCY (LAT),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [31:0] got, input logic [31:0] exp,
                     input string tag);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic w, input logic [1:0] sz,
                                input logic u, input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic flt,
                                output logic [31:0] rd);
    int          nb;
    logic [31:0] off;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = a - BASE;
    flt = (sz == 2'd3) || (off % nb != 0) || (off >= NB);
    rd  = 32'h0;
    if (!flt) begin
      if (w) begin
        for (int k = 0; k < nb; k++)
          ref_mem[off + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < nb; k++)
          v[8*k +: 8] = ref_mem[off + k];
        if (!u && nb < 4 && v[8*nb-1])
          for (int k = nb; k < 4; k++)
            v[8*k +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NB; i++)
      ref_mem[i] = 8'h00;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic use_c,
                       input logic [31:0] c_rd, input logic c_flt,
                       input string tag);
    int          k;
    logic        mf;
    logic [31:0] mrd;
    exp_t        e;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    k = 0;
    while (!bus.req_ready && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.req_ready) begin
      chk({31'h0, bus.req_ready}, 32'h1, {tag, "_ready_timeout"});
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.due = cyc + LAT;
    model(w, sz, u, a, wd, mf, mrd);
    e.rd  = use_c ? c_rd : mrd;
    e.flt = use_c ? c_flt : mf;
    e.tag = tag;
    expq.push_back(e);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic measure_ready(input string tag);
    int n;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n, NW, tag);
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.rsp_valid) begin
        chk(expq.size() > 0, 1, "spurious_rsp");
        if (expq.size() > 0) begin
          exp_t e;
          e = expq.pop_front();
          chk(cyc, e.due, {e.tag, "_timing"});
          chk(bus.rsp_rdata, e.rd, {e.tag, "_rdata"});
          chk({31'h0, bus.rsp_fault}, {31'h0, e.flt}, {e.tag, "_fault"});
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        exp_t e;
        e = expq.pop_front();
        chk({31'h0, bus.rsp_valid}, 32'h1, {e.tag, "_missing_rsp"});
      end
    end
  end

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    n_checks = 0;
    n_errors = 0;
    clear_model();
    n_rst            = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h3C;
    bus.req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk({31'h0, bus.req_ready}, 32'h0, "rst_ready");
    chk({31'h0, bus.rsp_valid}, 32'h0, "rst_valid");
    chk(bus.rsp_rdata, 32'h0, "rst_rdata");
    chk({31'h0, bus.rsp_fault}, 32'h0, "rst_fault");

    // sweep with a request already waiting
    n_rst = 1'b1;
    measure_ready("init_ready_cycles");
    issue(0, 2, 0, 32'h3C, 0, 1, 32'h0, 0, "lw_3c");

    issue(1, 2, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, "sw_10");
    issue(1, 0, 0, 32'h11, 32'h123456AA, 1, 32'h0, 0, "sb_11");
    issue(0, 2, 0, 32'h10, 0, 1, 32'hDEADAAEF, 0, "lw_10");
    issue(0, 0, 0, 32'h11, 0, 1, 32'hFFFFFFAA, 0, "lb_11");
    issue(0, 0, 1, 32'h11, 0, 1, 32'h000000AA, 0, "lbu_11");
    issue(0, 1, 0, 32'h12, 0, 1, 32'hFFFFDEAD, 0, "lh_12");
    issue(0, 1, 1, 32'h12, 0, 1, 32'h0000DEAD, 0, "lhu_12");

    issue(0, 1, 0, 32'h13, 0, 1, 32'h0, 1, "lh_13_misalign");
    issue(1, 2, 0, 32'h12, 32'hFFFFFFFF, 1, 32'h0, 1, "sw_12_misalign");
    issue(0, 2, 0, 32'h10, 0, 1, 32'hDEADAAEF, 0, "lw_10_after");
    issue(0, 3, 0, 32'h10, 0, 1, 32'h0, 1, "size3");

    issue(0, 2, 0, 32'h40, 0, 1, 32'h0, 1, "lw_40_range");
    issue(1, 2, 0, 32'h40, 32'h12345678, 1, 32'h0, 1, "sw_40_range");
    issue(0, 2, 0, 32'h00, 0, 1, 32'h0, 0, "lw_00_alias");
    issue(0, 2, 0, 32'hFFFFFFFC, 0, 1, 32'h0, 1, "lw_wrap");

    issue(1, 2, 0, 32'h20, 32'hCAFEF00D, 1, 32'h0, 0, "b2b_sw");
    issue(0, 2, 0, 32'h20, 0, 1, 32'hCAFEF00D, 0, "b2b_lw");
    for (int i = 0; i < 10; i++)
      issue(0, 2, 0, 32'(i * 4), 0, 0, 0, 0, "b2b_burst");

    repeat (40) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'($urandom_range(0, 71));
      issue(w, sz, u, a, $urandom, 0, 0, 0, "rand");
    end
    repeat (LAT + 1) @(posedge clk);
    #1;

    // reset with two loads in flight
    issue(0, 2, 0, 32'h20, 0, 0, 0, 0, "inflight0");
    issue(0, 2, 0, 32'h24, 0, 0, 0, 0, "inflight1");
    n_rst = 1'b0;
    expq.delete();
    clear_model();
    #1;
    chk({31'h0, bus.req_ready}, 32'h0, "midrst_ready");
    chk({31'h0, bus.rsp_valid}, 32'h0, "midrst_valid");
    chk(bus.rsp_rdata, 32'h0, "midrst_rdata");
    chk({31'h0, bus.rsp_fault}, 32'h0, "midrst_fault");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    measure_ready("midrst_ready_cycles");
    issue(0, 2, 0, 32'h20, 0, 1, 32'h0, 0, "lw_20_swept");

    // reset during the sweep restarts it from word 0
    repeat (LAT + 1) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    measure_ready("sweeprst_ready_cycles");
    issue(0, 2, 0, 32'h3C, 0, 1, 32'h0, 0, "lw_3c_swept");

    repeat (LAT + 2) @(posedge clk);
    #1;
    chk(expq.size(), 0, "drain");
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
Name: data_mem_bank

Overview:
- Parametrised successor to the single-cycle word data memory in the MEM stage.
- Supports RISC-V byte, half and word loads and stores, with sign or zero extension and byte-lane write enables.
- Detects misaligned and out-of-range accesses.
- Has a configurable read-latency pipeline and a post-reset clear sweep with a ready handshake, replacing the full-array clear in the reset branch.

Parameters:
- NUM_WORDS, 256, depth in 32-bit words; power of two, >= 4.
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present this cycle
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and faults
- req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for word and stores
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle pulse per accepted request
- rsp_rdata  output  32  extended load data; 0 for stores and faults
- rsp_fault  output  1  access misaligned, out of range, or illegal size

Behaviour:
Reset and ports:
- Clock is clk; reset is n_rst, asynchronous and active-low.
- On reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, state=INIT, init counter=0, response pipeline flushed.
- Array contents are not reset directly.

Clear sweep (FSM INIT -> READY):
- INIT: write 0 to word[cnt] each cycle and increment cnt.
- At cnt==NUM_WORDS-1, write it and go to READY the next cycle.
- req_ready is 0 throughout INIT; first asserted exactly NUM_WORDS cycles after reset release.
- READY: req_ready=1 constantly. There is no return to INIT except via reset.

Acceptance and addressing:
- A request is accepted when req_valid && req_ready. One request per cycle at most.
- off = req_addr - BASE_ADDR; index = off[31:2]; lane = off[1:0].

Fault conditions:
- size 1 with lane[0]=1, size 2 with lane!=0, size 3, or index >= NUM_WORDS (including off underflow/wrap).
- A faulting store writes nothing. A faulting load returns rdata 0.

Stores:
- Byte-enable mask: byte -> 1<<lane; half -> 2'b11<<lane; word -> 4'hF.
- Data is replicated to the lane position; the write commits at the acceptance edge.

Loads:
- Array read at the acceptance cycle using pre-edge contents.
- Extract the byte or half at lane; sign-extend unless req_unsigned; zero-extend when req_unsigned.

Response pipeline:
- Each accepted request enters a READ_LATENCY-deep pipeline of {valid, rdata, fault}.
- rsp_valid asserts exactly READ_LATENCY cycles after the acceptance edge, in request order.
- Back-to-back requests give back-to-back responses. There is no response backpressure.

Hazards:
- A store accepted in cycle N is visible to a load accepted in cycle N+1.
- Load and store in the same cycle are impossible (single port).

Reset mid-operation:
- In-flight responses are dropped and not replayed.
- Any store that committed before the reset edge remains, but the sweep re-zeros the array.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] mem_size_t {MEM_B, MEM_H, MEM_W, MEM_RSVD};
  - typedef enum logic state_t {ST_INIT, ST_READY};
  - typedef struct rsp_stage_t {valid, rdata[31:0], fault};
  - localparam MAX_READ_LATENCY = 4.
- One combinational sub-module, mem_lane_align:
  - Inputs: size, unsigned, lane, wdata, raw read word.
  - Outputs: byte-enable mask, lane-shifted store data, extended load data, misalign flag.
  - Range check, FSM, array and pipeline stay in data_mem_bank.

Test Plan (NUM_WORDS=16, READ_LATENCY=2, BASE_ADDR=0):
1. Release reset with req_valid=1 held -> req_ready low for 16 cycles, then high; no rsp_valid during INIT; LW 0x3C afterwards returns 0x0000_0000 with fault=0, two cycles after acceptance.
2. Store and load extension, each response exactly 2 cycles after its acceptance with fault=0:
   - SW 0x10 0xDEADBEEF, then SB 0x11 0x123456AA.
   - LW 0x10 -> 0xDEADAAEF.
   - LB 0x11 -> 0xFFFFFFAA.
   - LBU 0x11 -> 0x000000AA.
   - LH 0x12 -> 0xFFFFDEAD.
   - LHU 0x12 -> 0x0000DEAD.
3. Faults:
   - LH 0x13 -> fault=1, rdata=0.
   - SW 0x12 0xFFFFFFFF -> fault=1; then LW 0x10 still 0xDEADAAEF.
   - size=3 at 0x10 -> fault=1.
4. Range: LW 0x40 (index 16) -> fault=1, rdata=0; SW 0x40 does not alias word 0 (LW 0x00 still 0).
5. Back-to-back: SW 0x20 0xCAFEF00D in cycle N, LW 0x20 in N+1 -> rsp_valid in N+2 (store, rdata 0) and N+3 (0xCAFEF00D); ten consecutive loads yield ten consecutive rsp_valid pulses in order.
6. Reset mid-operation:
   - n_rst pulsed low with two loads in flight -> no rsp_valid after reset, all outputs 0, req_ready low 16 cycles.
   - n_rst pulsed low at INIT cycle 7 -> sweep restarts from 0; 16 full cycles before req_ready.
